div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Multi-cycle 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
- Sits in the EX stage beside the 64-bit carry-lookahead adder.
- Its {remainder, quotient} result feeds the same HI/LO writeback mux that the adder's MADD/MSUB accumulate path drives.
- Accepts one operation at a time, raises busy for the pipeline stall logic, and pulses result_valid when HI/LO data is ready.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits; internal working register is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
start  input  1  request a divide; sampled only in IDLE or DONE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
cancel  input  1  pipeline flush; aborts any operation
busy  output  1  high in PREP, RUN, FIX
result_valid  output  1  one-cycle pulse in DONE
quotient  output  WIDTH  LO value; held until next accepted start
remainder  output  WIDTH  HI value; held until next accepted start

Behaviour:
- Reset (resetn low, async): state = IDLE; busy, result_valid, quotient, remainder, counter and working register all 0. Reset mid-operation discards the operation; no result_valid follows.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE/DONE + start (cancel low):
  - latch operands and is_signed, go to PREP.
  - Start is ignored in PREP, RUN and FIX.
- PREP:
  - Compute |dividend| and |divisor| (magnitudes only when is_signed; 0x80000000 stays 0x80000000 as unsigned).
  - Record neg_q = signed & (sign_a ^ sign_b) and neg_r = signed & sign_a.
  - Set W = {0, |dividend|}, cnt = 0.
  - If divisor == 0: quotient = all-ones, remainder = raw dividend; go to DONE.
  - Otherwise go to RUN.
- RUN: one quotient bit per cycle.
  - T = W[2W-1:W-1] (WIDTH+1 bits) minus {0, |divisor|}, evaluated at WIDTH+1 bits.
  - If T is non-negative: W <= {T[WIDTH-1:0], W[WIDTH-2:0], 1}.
  - Else: W <= {W[2W-2:0], 0}.
  - cnt increments each cycle. After the cycle with cnt == WIDTH-1, go to FIX.
- FIX:
  - quotient = neg_q ? -W[W-1:0] : W[W-1:0].
  - remainder = neg_r ? -W[2W-1:W] : W[2W-1:W].
  - Go to DONE.
- DONE: result_valid = 1 for exactly this cycle, then IDLE unless a new start is accepted.
- Latency: start high in cycle 0 gives PREP in cycle 1, RUN in cycles 2..33, FIX in cycle 34, and result_valid in cycle 35. Divide-by-zero gives result_valid in cycle 2.
- cancel:
  - In any state, the next state is IDLE and result_valid is suppressed.
  - quotient/remainder keep their previous values.
  - cancel beats start in the same cycle.
- Overflow 0x80000000 / -1 (signed): quotient = 0x80000000, remainder = 0, normal latency.
- Remainder sign always follows the dividend; |remainder| < |divisor|.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 0, PREP = 1, RUN = 2, FIX = 3, DONE = 4 (3 bits);
  - DIV_WIDTH = 32;
  - DIV_ZERO_Q = 32'hFFFFFFFF.
- Sub-module div_negate (conditional two's-complement negate, WIDTH-bit, combinational). It is instantiated for operand magnitudes in PREP and for result correction in FIX.
- The trial subtraction stays inline in RUN, as a single WIDTH+1-bit subtract.

Test Plan:
- DIVU 100 / 7, start in cycle 0 -> busy high cycles 1-34; result_valid only in cycle 35; quotient = 14, remainder = 2.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF. DIV 7 / -2 -> quotient = 0xFFFFFFFD, remainder = 1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient = 0x80000000, remainder = 0. DIVU 0xFFFFFFFF / 1 -> quotient = 0xFFFFFFFF, remainder = 0.
- DIVU 0x1234 / 0 -> result_valid in cycle 2; quotient = 0xFFFFFFFF, remainder = 0x1234.
- Start 100/7, cancel in cycle 10 -> cycle 11 IDLE with busy 0; no result_valid ever; previous outputs held. A new start 9/3 in cycle 12 gives quotient = 3, remainder = 0 in cycle 47. Start + cancel in the same cycle is ignored.
- Start 100/7, resetn low in cycle 20 -> all outputs 0 immediately; no pulse after release. A back-to-back start in the DONE cycle is accepted and gives result_valid exactly 35 cycles later.

Source files
------------

// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_pkg
// Description : Shared state encoding and constants for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_iter_pkg;

    localparam int DIV_WIDTH = 32;

    // MIPS leaves the quotient of a divide-by-zero undefined; all-ones is ours
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_negate.sv
`default_nettype none
// ============================================================================
// Module      : div_negate
// Description : Conditional two's-complement negate (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module div_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // The most negative value maps onto itself, which is exactly the unsigned
    // magnitude the divider needs for it.
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU,
//               producing {remainder, quotient} for the HI/LO writeback mux.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    div_state_e r_state;
    div_state_e w_next;

    logic                 r_signed;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_bmag;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_w;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_quot;
    logic [WIDTH-1:0]     r_rem;

    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_amag;
    logic [WIDTH-1:0]     w_bmag;
    logic [WIDTH:0]       w_trial;
    logic                 w_last;
    logic                 w_div0;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_qfix;
    logic [WIDTH-1:0]     w_rfix;

    assign w_neg_a  = r_signed & r_a[WIDTH-1];
    assign w_neg_b  = r_signed & r_b[WIDTH-1];
    assign w_div0   = (r_b == '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept = start & ~cancel & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Upper half of W plus the next dividend bit, against the divisor magnitude
    assign w_trial  = r_w[2*WIDTH-1:WIDTH-1] - {1'b0, r_bmag};

    div_negate #(.WIDTH(WIDTH)) u_neg_dividend (
        .i_val (r_a),
        .i_neg (w_neg_a),
        .o_val (w_amag)
    );

    div_negate #(.WIDTH(WIDTH)) u_neg_divisor (
        .i_val (r_b),
        .i_neg (w_neg_b),
        .o_val (w_bmag)
    );

    div_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .i_val (r_w[WIDTH-1:0]),
        .i_neg (r_neg_q),
        .o_val (w_qfix)
    );

    div_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (r_w[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_r),
        .o_val (w_rfix)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (cancel) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next = start ? ST_PREP : ST_IDLE;
                ST_PREP: w_next = w_div0 ? ST_DONE : ST_RUN;
                ST_RUN:  w_next = w_last ? ST_FIX : ST_RUN;
                ST_FIX:  w_next = ST_DONE;
                ST_DONE: w_next = start ? ST_PREP : ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_bmag   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_w      <= '0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_rem    <= '0;
        end else begin
            if (w_accept) begin
                r_signed <= is_signed;
                r_a      <= dividend;
                r_b      <= divisor;
            end
            // A flush must leave HI/LO exactly as the last completed divide left them
            if (!cancel) begin
                case (r_state)
                    ST_PREP: begin
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_bmag  <= w_bmag;
                        r_w     <= {{WIDTH{1'b0}}, w_amag};
                        r_cnt   <= '0;
                        if (w_div0) begin
                            r_quot <= '1;
                            r_rem  <= r_a;
                        end
                    end
                    ST_RUN: begin
                        if (!w_trial[WIDTH]) begin
                            r_w <= {w_trial[WIDTH-1:0], r_w[WIDTH-2:0], 1'b1};
                        end else begin
                            r_w <= {r_w[2*WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_FIX: begin
                        r_quot <= w_qfix;
                        r_rem  <= w_rfix;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy         = (r_state == ST_PREP) | (r_state == ST_RUN) | (r_state == ST_FIX);
    assign result_valid = (r_state == ST_DONE) & ~cancel;
    assign quotient     = r_quot;
    assign remainder    = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Scoreboard bench for div_iter: latency, sign rules, flush, reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_signed;
    logic        cancel;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_iter #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .is_signed    (is_signed),
        .dividend     (dividend),
        .divisor      (divisor),
        .cancel       (cancel),
        .busy         (busy),
        .result_valid (result_valid),
        .quotient     (quotient),
        .remainder    (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: {remainder, quotient} from plain SV arithmetic
    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sd;
        sa = $signed(a);
        sd = $signed(b);
        if (b == 32'h0)
            return {a, DIV_ZERO_Q};
        if (!sg)
            return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'h0, 32'h8000_0000};
        return {32'(sa % sd), 32'(sa / sd)};
    endfunction

    always @(negedge clk) begin
        if (resetn && result_valid) begin
            if (sb_q.size() == 0) begin
                chk("spurious_result_valid", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("quotient", {32'h0, quotient}, {32'h0, e[31:0]});
                chk("remainder", {32'h0, remainder}, {32'h0, e[63:32]});
                last_q = e[31:0];
                last_r = e[63:32];
            end
        end
    end

    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(model(sg, a, b));
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
    endtask

    // Walks cycles 1..lat after the start cycle checking busy and the pulse slot
    task automatic wait_result(input int lat, input string tag);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            chk({tag, "_busy"}, {63'h0, busy}, (k < lat) ? 64'd1 : 64'd0);
            chk({tag, "_rv"}, {63'h0, result_valid}, (k == lat) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        resetn = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0; last_q = '0; last_r = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_rv",   {63'h0, result_valid}, 64'd0);
        chk("rst_q",    {32'h0, quotient}, 64'd0);
        chk("rst_r",    {32'h0, remainder}, 64'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", {63'h0, busy}, 64'd0);

        issue(1'b0, 32'd100, 32'd7);                 wait_result(35, "divu_100_7");
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);           wait_result(35, "div_m7_2");
        issue(1'b1, 32'd7, 32'hFFFF_FFFE);           wait_result(35, "div_7_m2");
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_result(35, "div_ovf");
        issue(1'b0, 32'hFFFF_FFFF, 32'd1);           wait_result(35, "divu_max_1");
        issue(1'b0, 32'h1234, 32'd0);                wait_result(2,  "divu_by0");
        issue(1'b1, 32'h8000_0000, 32'd3);           wait_result(35, "div_min_3");
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            issue(1'(i), ra, rb);
            wait_result((rb == 32'h0) ? 2 : 35, "rand");
        end

        // Flush mid-run: outputs hold, no pulse, then a fresh divide
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 10) cancel = 1'b1;
        end
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {63'h0, busy}, 64'd0);
        chk("cancel_hold_q", {32'h0, quotient}, {32'h0, last_q});
        chk("cancel_hold_r", {32'h0, remainder}, {32'h0, last_r});
        @(negedge clk);
        issue(1'b0, 32'd9, 32'd3);                   wait_result(35, "after_cancel");

        // Start and cancel together must not launch anything
        @(negedge clk);
        is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("start_cancel_busy", {63'h0, busy}, 64'd0);
            @(negedge clk);
        end

        // Asynchronous reset mid-run
        is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_rv",   {63'h0, result_valid}, 64'd0);
        chk("arst_q",    {32'h0, quotient}, 64'd0);
        chk("arst_r",    {32'h0, remainder}, 64'd0);
        last_q = '0; last_r = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k % 10 == 0) chk("post_rst_busy", {63'h0, busy}, 64'd0);
        end

        // Back-to-back: second start lands in the DONE cycle of the first
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);           wait_result(35, "b2b_a");
        issue(1'b0, 32'd1000, 32'd33);               wait_result(35, "b2b_b");

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
